// File: rtl/fpu_op_sequencer_if.sv
// Request, response and shared fadd/fmul unit signals of the FP op sequencer.
// The slave modport is the sequencer side; the master modport is the issue/datapath side.
interface fpu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] req_c;
  logic [2:0]  req_rm;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [2:0]  add_rm;
  logic [31:0] add_res;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [2:0]  mul_rm;
  logic [31:0] mul_res;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, req_rm, add_res, mul_res, resp_ready,
    output req_ready, add_a, add_b, add_rm, mul_a, mul_b, mul_rm, resp_valid, resp_data,
           resp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, req_rm, add_res, mul_res, resp_ready,
    input  req_ready, add_a, add_b, add_rm, mul_a, mul_b, mul_rm, resp_valid, resp_data,
           resp_err, busy
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Sequences one shared fadd and one shared fmul to run FADD/FSUB/FMUL and the chained
// FMSUB ((a-b)*c) / FMADD ((a+b)*c), one request at a time.
module fpu_op_sequencer #(
  parameter int ADD_CYCLES = 1,
  parameter int MUL_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  fpu_op_sequencer_if.slave bus
);
  localparam int MAX_CYCLES = (ADD_CYCLES > MUL_CYCLES) ? ADD_CYCLES : MUL_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] ADD_LAST = CW'(ADD_CYCLES - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [2:0]  OP_FADD  = 3'b000;
  localparam logic [2:0]  OP_FSUB  = 3'b001;
  localparam logic [2:0]  OP_FMUL  = 3'b010;
  localparam logic [2:0]  OP_FMSUB = 3'b011;
  localparam logic [2:0]  OP_FMADD = 3'b100;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, MUL = 2'd2, DONE = 2'd3} state_t;

  state_t        state_r, state_nxt_s;
  logic [2:0]    op_r, rm_r;
  logic [31:0]   a_r, b_r, c_r, tmp_r, resp_data_r;
  logic [CW-1:0] cnt_r;
  logic          resp_valid_r, resp_err_r;
  logic          accept_s, legal_s, chained_s, sub_s, add_last_s, mul_last_s;

  assign accept_s   = bus.req_valid && (state_r == IDLE);
  assign legal_s    = (bus.req_op <= OP_FMADD);
  assign chained_s  = (op_r == OP_FMSUB) || (op_r == OP_FMADD);
  assign sub_s      = (op_r == OP_FSUB) || (op_r == OP_FMSUB);
  assign add_last_s = (cnt_r == ADD_LAST);
  assign mul_last_s = (cnt_r == MUL_LAST);

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.busy       = (state_r != IDLE);
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_err   = resp_err_r;

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s)                   state_nxt_s = IDLE;
        else if (!legal_s)               state_nxt_s = DONE;
        else if (bus.req_op == OP_FMUL)  state_nxt_s = MUL;
        else                             state_nxt_s = ADD;
      end
      ADD: begin
        if (!add_last_s)     state_nxt_s = ADD;
        else if (chained_s)  state_nxt_s = MUL;
        else                 state_nxt_s = DONE;
      end
      MUL: begin
        if (mul_last_s) state_nxt_s = DONE;
        else            state_nxt_s = MUL;
      end
      DONE: begin
        if (bus.resp_ready) state_nxt_s = IDLE;
        else                state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Shared unit operand drive; ports rest at zero outside their own phase
  always_comb begin
    bus.add_a  = 32'd0;
    bus.add_b  = 32'd0;
    bus.add_rm = 3'd0;
    bus.mul_a  = 32'd0;
    bus.mul_b  = 32'd0;
    bus.mul_rm = 3'd0;
    case (state_r)
      ADD: begin
        bus.add_a  = a_r;
        bus.add_b  = sub_s ? {~b_r[31], b_r[30:0]} : b_r;
        bus.add_rm = rm_r;
      end
      MUL: begin
        if (op_r == OP_FMUL) begin
          bus.mul_a = a_r;
          bus.mul_b = b_r;
        end else begin
          bus.mul_a = tmp_r;
          bus.mul_b = c_r;
        end
        bus.mul_rm = rm_r;
      end
      default: begin
        bus.mul_rm = 3'd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Request latch, phase counter, intermediate and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= 3'd0; rm_r <= 3'd0;
      a_r <= 32'd0; b_r <= 32'd0; c_r <= 32'd0; tmp_r <= 32'd0;
      cnt_r <= '0;
      resp_valid_r <= 1'b0; resp_data_r <= 32'd0; resp_err_r <= 1'b0;
    end else begin
      if (state_nxt_s != state_r)                   cnt_r <= '0;
      else if ((state_r == ADD) || (state_r == MUL)) cnt_r <= cnt_r + CW'(1);
      else                                          cnt_r <= cnt_r;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r <= bus.req_op; rm_r <= bus.req_rm;
            a_r <= bus.req_a; b_r <= bus.req_b; c_r <= bus.req_c;
            if (!legal_s) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_data_r  <= QNAN;
            end
          end
        end
        ADD: begin
          if (add_last_s) begin
            tmp_r <= bus.add_res;
            if (!chained_s) begin
              resp_data_r  <= bus.add_res;
              resp_valid_r <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_last_s) begin
            resp_data_r  <= bus.mul_res;
            resp_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
          end
        end
        default: resp_valid_r <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Table-driven bench for fpu_op_sequencer with two parameterisations, behavioural fadd/fmul
// units that only produce a valid result after their operands have been held long enough.
module tb_fpu_op_sequencer;
  localparam int A0 = 1, M0 = 1, A1 = 3, M1 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_op_sequencer_if bus0();
  fpu_op_sequencer_if bus1();

  fpu_op_sequencer #(.ADD_CYCLES(A0), .MUL_CYCLES(M0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  fpu_op_sequencer #(.ADD_CYCLES(A1), .MUL_CYCLES(M1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  logic        dsel = 1'b0;
  logic        req_valid_t = 1'b0, resp_ready_t = 1'b0;
  logic [2:0]  req_op_t = 3'd0, req_rm_t = 3'd0;
  logic [31:0] req_a_t = 32'd0, req_b_t = 32'd0, req_c_t = 32'd0;

  assign bus0.req_valid  = req_valid_t & ~dsel;
  assign bus1.req_valid  = req_valid_t & dsel;
  assign bus0.resp_ready = resp_ready_t & ~dsel;
  assign bus1.resp_ready = resp_ready_t & dsel;
  assign bus0.req_op = req_op_t;  assign bus1.req_op = req_op_t;
  assign bus0.req_rm = req_rm_t;  assign bus1.req_rm = req_rm_t;
  assign bus0.req_a  = req_a_t;   assign bus1.req_a  = req_a_t;
  assign bus0.req_b  = req_b_t;   assign bus1.req_b  = req_b_t;
  assign bus0.req_c  = req_c_t;   assign bus1.req_c  = req_c_t;

  // FP32 <-> real conversion, exact for normals and zero
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], {3'd0, x[30:23]} + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) + f2r(y));
  endfunction
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) * f2r(y));
  endfunction

  // Unit models: edges operands have been held; result is garbage until held long enough
  logic [3:0] ah0 = 4'd0, mh0 = 4'd0, ah1 = 4'd0, mh1 = 4'd0;
  always_ff @(posedge clk) begin
    ah0 <= ((bus0.add_a | bus0.add_b) != 32'd0) ? ah0 + 4'd1 : 4'd0;
    mh0 <= ((bus0.mul_a | bus0.mul_b) != 32'd0) ? mh0 + 4'd1 : 4'd0;
    ah1 <= ((bus1.add_a | bus1.add_b) != 32'd0) ? ah1 + 4'd1 : 4'd0;
    mh1 <= ((bus1.mul_a | bus1.mul_b) != 32'd0) ? mh1 + 4'd1 : 4'd0;
  end
  always_comb begin
    bus0.add_res = (ah0 >= 4'(A0 - 1)) ? fadd(bus0.add_a, bus0.add_b) : 32'hDEAD_BEEF;
    bus0.mul_res = (mh0 >= 4'(M0 - 1)) ? fmul(bus0.mul_a, bus0.mul_b) : 32'hDEAD_BEEF;
    bus1.add_res = (ah1 >= 4'(A1 - 1)) ? fadd(bus1.add_a, bus1.add_b) : 32'hDEAD_BEEF;
    bus1.mul_res = (mh1 >= 4'(M1 - 1)) ? fmul(bus1.mul_a, bus1.mul_b) : 32'hDEAD_BEEF;
  end

  logic        rv_s, rerr_s, rdy_s, busy_s;
  logic [31:0] rdata_s, add_a_s, add_b_s, mul_a_s, mul_b_s;
  logic [2:0]  add_rm_s, mul_rm_s;
  always_comb begin
    rv_s     = dsel ? bus1.resp_valid : bus0.resp_valid;
    rerr_s   = dsel ? bus1.resp_err   : bus0.resp_err;
    rdata_s  = dsel ? bus1.resp_data  : bus0.resp_data;
    rdy_s    = dsel ? bus1.req_ready  : bus0.req_ready;
    busy_s   = dsel ? bus1.busy       : bus0.busy;
    add_a_s  = dsel ? bus1.add_a      : bus0.add_a;
    add_b_s  = dsel ? bus1.add_b      : bus0.add_b;
    add_rm_s = dsel ? bus1.add_rm     : bus0.add_rm;
    mul_a_s  = dsel ? bus1.mul_a      : bus0.mul_a;
    mul_b_s  = dsel ? bus1.mul_b      : bus0.mul_b;
    mul_rm_s = dsel ? bus1.mul_rm     : bus0.mul_rm;
  end

  typedef struct {
    logic        s;
    logic [2:0]  op, rm;
    logic [31:0] a, b, c, ed;
    logic        ee;
    int          lat, hold;
  } vec_t;
  typedef struct { logic [31:0] data; logic err; } exp_t;

  exp_t sb_q[$];
  vec_t vt[14];
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One transaction; starts and ends 1 time unit after a rising edge.
  // Latency counts edges from and including the accept edge until resp_valid reads high.
  task automatic run_vec(input vec_t v);
    logic [31:0] eaa, eab, ema, emb;
    exp_t e;
    int lat;
    dsel = v.s;
    eab = ((v.op == 3'b001) || (v.op == 3'b011)) ? {~v.b[31], v.b[30:0]} : v.b;
    eaa = (v.op == 3'b010) ? 32'd0 : v.a;
    if (v.op == 3'b010) eab = 32'd0;
    ema = (v.op == 3'b010) ? v.a : (((v.op == 3'b011) || (v.op == 3'b100)) ? fadd(v.a, eab) : 32'd0);
    emb = (v.op == 3'b010) ? v.b : (((v.op == 3'b011) || (v.op == 3'b100)) ? v.c : 32'd0);
    #1;
    chk("req_ready_idle", {31'd0, rdy_s}, 32'd1);
    req_op_t = v.op; req_rm_t = v.rm; req_a_t = v.a; req_b_t = v.b; req_c_t = v.c;
    req_valid_t = 1'b1;
    sb_q.push_back('{v.ed, v.ee});
    @(posedge clk); #1;
    req_valid_t = 1'b0;
    lat = 1;
    while (!rv_s && lat < 40) begin
      if ((add_a_s | add_b_s) != 32'd0) begin
        chk("add_a", add_a_s, eaa);
        chk("add_b", add_b_s, eab);
        chk("add_rm", {29'd0, add_rm_s}, {29'd0, v.rm});
      end
      if ((mul_a_s | mul_b_s) != 32'd0) begin
        chk("mul_a", mul_a_s, ema);
        chk("mul_b", mul_b_s, emb);
        chk("mul_rm", {29'd0, mul_rm_s}, {29'd0, v.rm});
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("ports_idle_done", add_a_s | add_b_s | mul_a_s | mul_b_s, 32'd0);
    // Stall the consumer while a competing request is offered
    for (int h = 0; h < v.hold; h++) begin
      req_valid_t = 1'b1; req_op_t = 3'b000; req_a_t = 32'h4110_0000;
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, rv_s}, 32'd1);
      chk("hold_data", rdata_s, v.ed);
      chk("hold_req_ready", {31'd0, rdy_s}, 32'd0);
    end
    resp_ready_t = 1'b1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("resp_data", rdata_s, e.data);
      chk("resp_err", {31'd0, rerr_s}, {31'd0, e.err});
    end
    @(posedge clk); #1;
    resp_ready_t = 1'b0;
    req_valid_t = 1'b0;
    chk("resp_valid_clear", {31'd0, rv_s}, 32'd0);
    chk("resp_err_clear", {31'd0, rerr_s}, 32'd0);
    chk("busy_clear", {31'd0, busy_s}, 32'd0);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 3'b000, 3'b000, 32'h3F80_0000, 32'h3F80_0000, 32'd0, 32'h4000_0000, 1'b0, 2, 0};
    vt[1]  = '{1'b0, 3'b001, 3'b000, 32'h4040_0000, 32'h3F80_0000, 32'd0, 32'h4000_0000, 1'b0, 2, 0};
    vt[2]  = '{1'b0, 3'b011, 3'b000, 32'h4040_0000, 32'h3F80_0000, 32'h4020_0000, 32'h40A0_0000, 1'b0, 3, 0};
    vt[3]  = '{1'b0, 3'b100, 3'b010, 32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 3, 0};
    vt[4]  = '{1'b0, 3'b010, 3'b000, 32'h4000_0000, 32'h4040_0000, 32'd0, 32'h40C0_0000, 1'b0, 2, 5};
    vt[5]  = '{1'b0, 3'b101, 3'b000, 32'h3F80_0000, 32'h3F80_0000, 32'd0, 32'h7FC0_0000, 1'b1, 1, 0};
    vt[6]  = '{1'b0, 3'b000, 3'b000, 32'h3F80_0000, 32'h3F80_0000, 32'd0, 32'h4000_0000, 1'b0, 2, 0};
    vt[7]  = '{1'b0, 3'b111, 3'b001, 32'h4040_0000, 32'h3F80_0000, 32'd0, 32'h7FC0_0000, 1'b1, 1, 2};
    vt[8]  = '{1'b0, 3'b001, 3'b011, 32'h3F80_0000, 32'hC000_0000, 32'd0, 32'h4040_0000, 1'b0, 2, 0};
    vt[9]  = '{1'b0, 3'b010, 3'b100, 32'h3FC0_0000, 32'hC000_0000, 32'd0, 32'hC040_0000, 1'b0, 2, 0};
    vt[10] = '{1'b1, 3'b100, 3'b000, 32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 6, 0};
    vt[11] = '{1'b1, 3'b001, 3'b000, 32'h4040_0000, 32'h3F80_0000, 32'd0, 32'h4000_0000, 1'b0, 4, 1};
    vt[12] = '{1'b1, 3'b010, 3'b000, 32'h4000_0000, 32'h4040_0000, 32'd0, 32'h40C0_0000, 1'b0, 3, 0};
    vt[13] = '{1'b1, 3'b011, 3'b001, 32'h4040_0000, 32'h3F80_0000, 32'h4020_0000, 32'h40A0_0000, 1'b0, 6, 0};

    #1;
    chk("rst_resp_valid", {31'd0, bus0.resp_valid}, 32'd0);
    chk("rst_resp_data", bus0.resp_data, 32'd0);
    chk("rst_resp_err", {31'd0, bus0.resp_err}, 32'd0);
    chk("rst_busy", {31'd0, bus0.busy}, 32'd0);
    chk("rst_req_ready", {31'd0, bus0.req_ready}, 32'd1);
    chk("rst_ports", bus0.add_a | bus0.add_b | bus0.mul_a | bus0.mul_b, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 14; i++) run_vec(vt[i]);

    // Reset pulse during the MUL phase of an FMSUB aborts with no response
    dsel = 1'b0;
    #1;
    req_op_t = 3'b011; req_rm_t = 3'b000;
    req_a_t = 32'h4040_0000; req_b_t = 32'h3F80_0000; req_c_t = 32'h4020_0000;
    req_valid_t = 1'b1;
    @(posedge clk); #1;
    req_valid_t = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_mul", bus0.mul_a, 32'h4000_0000);
    rst_n = 1'b0;
    #1;
    chk("abort_resp_valid", {31'd0, bus0.resp_valid}, 32'd0);
    chk("abort_busy", {31'd0, bus0.busy}, 32'd0);
    chk("abort_ports", bus0.add_a | bus0.add_b | bus0.mul_a | bus0.mul_b, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_resp", {31'd0, bus0.resp_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_no_resp_after", {31'd0, bus0.resp_valid}, 32'd0);
    @(posedge clk);
    run_vec(vt[0]);

    if (sb_q.size() != 0) chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
